instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Instruction-fetch stage. Owns the architectural fetch PC, feeds it to the PC
//   controller (pc_in) and receives that block's computed next PC (pc_value).
//   Issues req/ack fetches to instruction memory, buffers one fetched
//   instruction and presents it to decode over a valid/ready interface.
//   A redirect input flushes and restarts fetch from a new address.
// PARAMETERS
//   DWIDTH    32            address/instruction width
//   RESET_PC  32'h0000_0000 first fetch address after reset
//   NOP_INSTR 32'h0000_0013 instruction word driven when no valid data (addi x0,x0,0)
// PORTS
//   clk         in   1      clock, all state on rising edge
//   rst_n       in   1      reset, asynchronous, active-low
//   fetch_pc    out  DWIDTH current fetch address; drives PC controller pc_in
//   next_pc     in   DWIDTH next address from PC controller pc_value
//   redirect    in   1      flush request (branch/jump resolved)
//   redirect_pc in   DWIDTH restart address, sampled when redirect=1
//   imem_req    out  1      memory request, held until imem_ack
//   imem_addr   out  DWIDTH request address (= fetch_pc)
//   imem_ack    in   1      memory response strobe, >=0 cycles after req
//   imem_rdata  in   DWIDTH instruction word, valid when imem_ack=1
//   if_valid    out  1      fetched instruction available to decode
//   if_ready    in   1      decode accepts when if_valid&&if_ready
//   if_pc       out  DWIDTH address of presented instruction
//   if_instr    out  DWIDTH presented instruction word
//   if_err      out  1      misaligned fetch (fetch_pc[1:0]!=0); if_instr=NOP_INSTR
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, fetch_pc=RESET_PC, if_valid=0, if_pc=0,
//     if_instr=NOP_INSTR, if_err=0; imem_req=0 (combinational, 0 in IDLE).
//   States: IDLE, REQ, OUT, DRAIN.
//   IDLE: -> REQ on first clock after rst_n deasserts.
//   REQ: imem_req=1 iff fetch_pc[1:0]==0; imem_addr=fetch_pc.
//     aligned & imem_ack: if_instr<=imem_rdata, if_pc<=fetch_pc, if_err<=0,
//       if_valid<=1 -> OUT.
//     misaligned: no request; if_instr<=NOP_INSTR, if_pc<=fetch_pc, if_err<=1,
//       if_valid<=1 -> OUT (one cycle, no memory access).
//   OUT: if_valid=1, outputs stable while !if_ready.
//     if_ready=1: accept; fetch_pc<=next_pc (sampled this cycle), if_valid<=0 -> REQ.
//   DRAIN: ack owed for a flushed request; imem_req=1 held with old address
//     (held latch); on imem_ack: discard data, fetch_pc<=pending_pc -> REQ.
//   Redirect (highest priority, any state except IDLE):
//     REQ, no ack this cycle & request issued: pending_pc<=redirect_pc -> DRAIN.
//     REQ, ack same cycle or misaligned: discard, fetch_pc<=redirect_pc -> REQ.
//     OUT: if_valid<=0 (no accept even if if_ready=1), fetch_pc<=redirect_pc -> REQ.
//     DRAIN: pending_pc<=redirect_pc (latest wins), stay DRAIN until ack.
//   imem_req/imem_addr never change while a request is outstanding (until ack).
//   Latency: zero-wait memory -> ack in REQ cycle, if_valid next cycle; steady
//     throughput one instruction per 2 cycles with if_ready=1.
//   PC arithmetic done by PC controller; this block only registers addresses,
//     wrap-around at 2^DWIDTH is inherited unchanged.
//   Reset asserted mid-fetch: immediate return to reset values; outstanding ack
//     after reset release is ignored (IDLE/REQ ignore ack without req).
// TESTING
//   Reset, RESET_PC=0x100, zero-wait mem returning 0xA0: -> imem_addr=0x100,
//     if_valid=1 with if_pc=0x100, if_instr=0xA0 one cycle after ack.
//   Sequential run, next_pc=fetch_pc+4, if_ready=1: if_pc 0x100,0x104,0x108 every 2 cycles.
//   if_ready=0 for 5 cycles in OUT: if_valid/if_pc/if_instr stable; imem_req=0.
//   Mem ack delayed 3 cycles, redirect to 0x200 in cycle 1: req held at old addr,
//     data discarded, next imem_addr=0x200, decode never sees old word.
//   Redirect while OUT with if_ready=1: no handshake, next fetch at redirect_pc.
//   next_pc=0x102: if_valid=1, if_err=1, if_instr=0x13, imem_req stays 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs req/ack fetches to instruction memory and
// buffers one instruction for decode behind a valid/ready handshake, with redirect flushing.
module instr_fetch_unit #(
    parameter int unsigned        DWIDTH    = 32,
    parameter logic [DWIDTH-1:0] RESET_PC  = '0,
    parameter logic [DWIDTH-1:0] NOP_INSTR = DWIDTH'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DWIDTH-1:0] fetch_pc,
    input  logic [DWIDTH-1:0] next_pc,
    input  logic              redirect,
    input  logic [DWIDTH-1:0] redirect_pc,
    output logic              imem_req,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DWIDTH-1:0] if_pc,
    output logic [DWIDTH-1:0] if_instr,
    output logic              if_err
);

    typedef enum logic [1:0] {StIdle, StReq, StOut, StDrain} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [DWIDTH-1:0]   r_fetch_pc;
    logic [DWIDTH-1:0]   w_fetch_pc_d;
    logic [DWIDTH-1:0]   r_pending_pc;
    logic [DWIDTH-1:0]   w_pending_pc_d;
    logic                r_if_valid;
    logic                w_if_valid_d;
    logic [DWIDTH-1:0]   r_if_pc;
    logic [DWIDTH-1:0]   w_if_pc_d;
    logic [DWIDTH-1:0]   r_if_instr;
    logic [DWIDTH-1:0]   w_if_instr_d;
    logic                r_if_err;
    logic                w_if_err_d;
    logic                w_aligned;

    assign w_aligned = (r_fetch_pc[1:0] == 2'b00);

    // The fetch PC stays put in DRAIN, so the outstanding request's address is held for free.
    assign imem_req  = ((r_state == StReq) && w_aligned) || (r_state == StDrain);
    assign imem_addr = r_fetch_pc;
    assign fetch_pc  = r_fetch_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign if_err    = r_if_err;

    always_comb begin
        w_state_d      = r_state;
        w_fetch_pc_d   = r_fetch_pc;
        w_pending_pc_d = r_pending_pc;
        w_if_valid_d   = r_if_valid;
        w_if_pc_d      = r_if_pc;
        w_if_instr_d   = r_if_instr;
        w_if_err_d     = r_if_err;

        unique case (r_state)
            StIdle: begin
                w_state_d = StReq;
            end
            StReq: begin
                if (redirect) begin
                    if (w_aligned && !imem_ack) begin
                        // Request is in flight: its ack must be swallowed before refetching.
                        w_pending_pc_d = redirect_pc;
                        w_state_d      = StDrain;
                    end else begin
                        w_fetch_pc_d = redirect_pc;
                        w_state_d    = StReq;
                    end
                end else if (!w_aligned) begin
                    w_if_instr_d = NOP_INSTR;
                    w_if_pc_d    = r_fetch_pc;
                    w_if_err_d   = 1'b1;
                    w_if_valid_d = 1'b1;
                    w_state_d    = StOut;
                end else if (imem_ack) begin
                    w_if_instr_d = imem_rdata;
                    w_if_pc_d    = r_fetch_pc;
                    w_if_err_d   = 1'b0;
                    w_if_valid_d = 1'b1;
                    w_state_d    = StOut;
                end
            end
            StOut: begin
                if (redirect) begin
                    w_if_valid_d = 1'b0;
                    w_fetch_pc_d = redirect_pc;
                    w_state_d    = StReq;
                end else if (if_ready) begin
                    w_if_valid_d = 1'b0;
                    w_fetch_pc_d = next_pc;
                    w_state_d    = StReq;
                end
            end
            StDrain: begin
                if (imem_ack) begin
                    w_fetch_pc_d = redirect ? redirect_pc : r_pending_pc;
                    w_state_d    = StReq;
                end else if (redirect) begin
                    w_pending_pc_d = redirect_pc;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_fetch_pc   <= RESET_PC;
            r_pending_pc <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_pc      <= '0;
            r_if_instr   <= NOP_INSTR;
            r_if_err     <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_fetch_pc   <= w_fetch_pc_d;
            r_pending_pc <= w_pending_pc_d;
            r_if_valid   <= w_if_valid_d;
            r_if_pc      <= w_if_pc_d;
            r_if_instr   <= w_if_instr_d;
            r_if_err     <= w_if_err_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand sequences for
// delayed-ack redirect and reset during an outstanding fetch.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_err;

    int n_vec  = 0;
    int n_miss = 0;

    // Memory: word = addr - 0x100 + 0xA0; ack after mem_delay cycles of held request.
    int unsigned mem_delay = 0;
    int unsigned mem_cnt   = 0;

    assign imem_ack   = imem_req && (mem_cnt == mem_delay);
    assign imem_rdata = imem_addr - 32'h100 + 32'hA0;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) mem_cnt <= 0;
        else                       mem_cnt <= mem_cnt + 1;
    end

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DWIDTH   (32),
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(32'h0000_0013)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_pc   (fetch_pc),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_err     (if_err)
    );

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] npc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_err;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit later, well away from the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        if_ready    = v.ready;
        next_pc     = v.npc;
        #1;
        chk({tag, ".imem_req"},  32'(imem_req),  32'(v.e_req));
        chk({tag, ".imem_addr"}, imem_addr,      v.e_addr);
        chk({tag, ".if_valid"},  32'(if_valid),  32'(v.e_valid));
        chk({tag, ".if_pc"},     if_pc,          v.e_pc);
        chk({tag, ".if_instr"},  if_instr,       v.e_instr);
        chk({tag, ".if_err"},    32'(if_err),    32'(v.e_err));
    endtask

    initial begin
        vec_t v;
        bit   seen;

        //          rdr rpc          rdy npc           req addr         vld pc           instr        err
        vecs[0]  = '{0, 32'h0,       1, 32'h0,        0, 32'h100,      0, 32'h0,        32'h13,      0};
        vecs[1]  = '{0, 32'h0,       1, 32'h0,        1, 32'h100,      0, 32'h0,        32'h13,      0};
        vecs[2]  = '{0, 32'h0,       1, 32'h104,      0, 32'h100,      1, 32'h100,      32'hA0,      0};
        vecs[3]  = '{0, 32'h0,       1, 32'h0,        1, 32'h104,      0, 32'h100,      32'hA0,      0};
        vecs[4]  = '{0, 32'h0,       0, 32'h108,      0, 32'h104,      1, 32'h104,      32'hA4,      0};
        vecs[5]  = '{0, 32'h0,       0, 32'h108,      0, 32'h104,      1, 32'h104,      32'hA4,      0};
        vecs[6]  = '{0, 32'h0,       0, 32'h108,      0, 32'h104,      1, 32'h104,      32'hA4,      0};
        vecs[7]  = '{0, 32'h0,       0, 32'h108,      0, 32'h104,      1, 32'h104,      32'hA4,      0};
        vecs[8]  = '{0, 32'h0,       0, 32'h108,      0, 32'h104,      1, 32'h104,      32'hA4,      0};
        vecs[9]  = '{0, 32'h0,       1, 32'h108,      0, 32'h104,      1, 32'h104,      32'hA4,      0};
        vecs[10] = '{0, 32'h0,       1, 32'h0,        1, 32'h108,      0, 32'h104,      32'hA4,      0};
        vecs[11] = '{1, 32'h300,     1, 32'h10C,      0, 32'h108,      1, 32'h108,      32'hA8,      0};
        vecs[12] = '{0, 32'h0,       1, 32'h0,        1, 32'h300,      0, 32'h108,      32'hA8,      0};
        vecs[13] = '{0, 32'h0,       1, 32'h102,      0, 32'h300,      1, 32'h300,      32'h2A0,     0};
        vecs[14] = '{0, 32'h0,       1, 32'h0,        0, 32'h102,      0, 32'h300,      32'h2A0,     0};
        vecs[15] = '{0, 32'h0,       1, 32'h104,      0, 32'h102,      1, 32'h102,      32'h13,      1};
        vecs[16] = '{0, 32'h0,       1, 32'h0,        1, 32'h104,      0, 32'h102,      32'h13,      1};
        vecs[17] = '{0, 32'h0,       1, 32'h108,      0, 32'h104,      1, 32'h104,      32'hA4,      0};

        // Release reset just after a rising edge so the first vector sees IDLE.
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 18; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Delayed-ack fetch of 0x108, redirected to 0x200 while the request is outstanding.
        mem_delay = 3;
        for (int i = 0; i < 8; i++) begin
            v = '{(i == 1), 32'h200, 1, 32'h0, 1, (i < 4) ? 32'h108 : 32'h200, 0, 32'h104,
                  32'hA4, 0};
            apply(v, $sformatf("drain%0d", i));
        end
        v = '{0, 32'h0, 0, 32'h0, 0, 32'h200, 1, 32'h200, 32'h1A0, 0};
        apply(v, "drain_out");

        // Accept, then pull reset while the next fetch (0x204) is still waiting for its ack.
        v = '{0, 32'h0, 1, 32'h204, 0, 32'h200, 1, 32'h200, 32'h1A0, 0};
        apply(v, "pre_rst");
        v = '{0, 32'h0, 1, 32'h0, 1, 32'h204, 0, 32'h200, 32'h1A0, 0};
        apply(v, "pre_rst_req");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst.imem_req", 32'(imem_req), 32'h0);
        chk("rst.fetch_pc", fetch_pc,      32'h100);
        chk("rst.if_valid", 32'(if_valid), 32'h0);
        chk("rst.if_pc",    if_pc,         32'h0);
        chk("rst.if_instr", if_instr,      32'h13);

        @(posedge clk);
        #2 rst_n = 1'b1;
        v = '{0, 32'h0, 0, 32'h0, 0, 32'h100, 0, 32'h0, 32'h13, 0};
        apply(v, "post_rst_idle");

        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (if_valid) seen = 1'b1;
        end
        chk("post_rst.valid_seen", 32'(seen), 32'h1);
        chk("post_rst.if_pc",      if_pc,     32'h100);
        chk("post_rst.if_instr",   if_instr,  32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
